// File: rtl/l1c_pkg.sv
// Shared types and address-field width helpers for the L1 data cache controller.
package l1c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_WB,
      ST_FILL,
      ST_RESP
   } l1c_state_e;

   function automatic int l1c_off_w(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int l1c_idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int l1c_tag_w(input int addr_w, input int sets, input int line_bytes);
      return addr_w - $clog2(sets) - $clog2(line_bytes);
   endfunction

endpackage

// File: rtl/l1c_lru.sv
// Per-set age-based LRU tracker; the way holding the maximum age is the replacement candidate.
module l1c_lru #(
   parameter int WAYS = 2,
   parameter int SETS = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      touch_en,
   input  logic [$clog2(SETS)-1:0]   touch_set,
   input  logic [$clog2(WAYS)-1:0]   touch_way,
   input  logic [$clog2(SETS)-1:0]   rd_set,
   output logic [$clog2(WAYS)-1:0]   victim_way
);

   localparam int WAY_W = $clog2(WAYS);

   logic [WAY_W-1:0] age_q [SETS][WAYS];
   logic [WAY_W-1:0] age_d [SETS][WAYS];

   // Ages younger than the touched way grow by one, so the set stays a permutation.
   always_comb begin
      age_d = age_q;
      if (touch_en) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touch_way) begin
               age_d[touch_set][w] = '0;
            end else if (age_q[touch_set][w] < age_q[touch_set][touch_way]) begin
               age_d[touch_set][w] = age_q[touch_set][w] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      victim_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (age_q[rd_set][w] == WAY_W'(WAYS - 1)) begin
            victim_way = WAY_W'(w);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               age_q[s][w] <= WAY_W'(w);
            end
         end
      end else begin
         age_q <= age_d;
      end
   end

endmodule

// File: rtl/l1_cache_ctrl.sv
// Set-associative write-back L1 data cache: byte-wide CPU port, single-beat line port to L2.
//  state  | meaning
//  IDLE   | ready for a CPU request; accept latches addr/we/wdata
//  LOOKUP | tag compare; hit responds here, miss picks a victim
//  WB     | write dirty victim line back to L2
//  FILL   | request line from L2, then wait for the data beat
//  RESP   | miss response from the freshly filled line
module l1_cache_ctrl
   import l1c_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int WAYS       = 2,
   parameter int SETS       = 16,
   parameter int LINE_BYTES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cpu_req_valid,
   output logic                      cpu_req_ready,
   input  logic                      cpu_we,
   input  logic [ADDR_W-1:0]         cpu_addr,
   input  logic [7:0]                cpu_wdata,
   output logic                      cpu_rsp_valid,
   output logic [7:0]                cpu_rdata,
   output logic                      cpu_rsp_hit,
   output logic                      l2_req_valid,
   input  logic                      l2_req_ready,
   output logic                      l2_req_we,
   output logic [ADDR_W-1:0]         l2_req_addr,
   output logic [8*LINE_BYTES-1:0]   l2_wdata,
   input  logic                      l2_rsp_valid,
   input  logic [8*LINE_BYTES-1:0]   l2_rdata
);

   localparam int OFF_W  = l1c_off_w(LINE_BYTES);
   localparam int IDX_W  = l1c_idx_w(SETS);
   localparam int TAG_W  = l1c_tag_w(ADDR_W, SETS, LINE_BYTES);
   localparam int LINE_W = 8 * LINE_BYTES;
   localparam int WAY_W  = $clog2(WAYS);

   l1c_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic                req_we_q, req_we_d;
   logic [7:0]          req_wdata_q, req_wdata_d;
   logic [WAY_W-1:0]    victim_q, victim_d;
   logic                fill_wait_q, fill_wait_d;
   logic [7:0]          rsp_rdata_q, rsp_rdata_d;

   logic                valid_q [WAYS][SETS];
   logic                valid_d [WAYS][SETS];
   logic                dirty_q [WAYS][SETS];
   logic                dirty_d [WAYS][SETS];
   logic [TAG_W-1:0]    tag_q   [WAYS][SETS];
   logic [TAG_W-1:0]    tag_d   [WAYS][SETS];
   logic [LINE_W-1:0]   data_q  [WAYS][SETS];
   logic [LINE_W-1:0]   data_d  [WAYS][SETS];

   logic [TAG_W-1:0]    req_tag;
   logic [IDX_W-1:0]    req_idx;
   logic [OFF_W-1:0]    req_off;

   logic                hit;
   logic [WAY_W-1:0]    hit_way;
   logic                has_inv;
   logic [WAY_W-1:0]    inv_way;
   logic [WAY_W-1:0]    lru_way;
   logic [WAY_W-1:0]    miss_victim;
   logic [LINE_W-1:0]   hit_line;
   logic [7:0]          hit_byte;
   logic [LINE_W-1:0]   line_v;
   logic                touch_en;
   logic [WAY_W-1:0]    touch_way;

   assign req_tag = req_addr_q[ADDR_W-1 -: TAG_W];
   assign req_idx = req_addr_q[OFF_W +: IDX_W];
   assign req_off = req_addr_q[OFF_W-1:0];

   l1c_lru #(
      .WAYS (WAYS),
      .SETS (SETS)
   ) u_lru (
      .clk        (clk),
      .rst_n      (rst_n),
      .touch_en   (touch_en),
      .touch_set  (req_idx),
      .touch_way  (touch_way),
      .rd_set     (req_idx),
      .victim_way (lru_way)
   );

   // Lowest-index match wins for both the hit way and the free way.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      has_inv = 1'b0;
      inv_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!has_inv && !valid_q[w][req_idx]) begin
            has_inv = 1'b1;
            inv_way = WAY_W'(w);
         end
      end
      miss_victim = has_inv ? inv_way : lru_way;
      hit_line    = data_q[hit_way][req_idx];
      hit_byte    = hit_line[{req_off, 3'b000} +: 8];
   end

   always_comb begin
      state_d       = state_q;
      req_addr_d    = req_addr_q;
      req_we_d      = req_we_q;
      req_wdata_d   = req_wdata_q;
      victim_d      = victim_q;
      fill_wait_d   = fill_wait_q;
      rsp_rdata_d   = rsp_rdata_q;
      valid_d       = valid_q;
      dirty_d       = dirty_q;
      tag_d         = tag_q;
      data_d        = data_q;
      line_v        = '0;
      touch_en      = 1'b0;
      touch_way     = '0;
      cpu_req_ready = 1'b0;
      cpu_rsp_valid = 1'b0;
      cpu_rdata     = '0;
      cpu_rsp_hit   = 1'b0;
      l2_req_valid  = 1'b0;
      l2_req_we     = 1'b0;
      l2_req_addr   = '0;
      l2_wdata      = '0;

      case (state_q)
         ST_IDLE: begin
            cpu_req_ready = 1'b1;
            if (cpu_req_valid) begin
               req_addr_d  = cpu_addr;
               req_we_d    = cpu_we;
               req_wdata_d = cpu_wdata;
               state_d     = ST_LOOKUP;
            end
         end

         ST_LOOKUP: begin
            if (hit) begin
               cpu_rsp_valid = 1'b1;
               cpu_rsp_hit   = 1'b1;
               cpu_rdata     = hit_byte;
               if (req_we_q) begin
                  line_v                          = hit_line;
                  line_v[{req_off, 3'b000} +: 8]  = req_wdata_q;
                  data_d[hit_way][req_idx]        = line_v;
                  dirty_d[hit_way][req_idx]       = 1'b1;
               end
               touch_en  = 1'b1;
               touch_way = hit_way;
               state_d   = ST_IDLE;
            end else begin
               victim_d    = miss_victim;
               fill_wait_d = 1'b0;
               if (valid_q[miss_victim][req_idx] && dirty_q[miss_victim][req_idx]) begin
                  state_d = ST_WB;
               end else begin
                  state_d = ST_FILL;
               end
            end
         end

         ST_WB: begin
            l2_req_valid = 1'b1;
            l2_req_we    = 1'b1;
            l2_req_addr  = {tag_q[victim_q][req_idx], req_idx, {OFF_W{1'b0}}};
            l2_wdata     = data_q[victim_q][req_idx];
            if (l2_req_ready) begin
               dirty_d[victim_q][req_idx] = 1'b0;
               state_d                    = ST_FILL;
            end
         end

         ST_FILL: begin
            // Data is only sampled after the request handshake cycle.
            if (!fill_wait_q) begin
               l2_req_valid = 1'b1;
               l2_req_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
               if (l2_req_ready) begin
                  fill_wait_d = 1'b1;
               end
            end else if (l2_rsp_valid) begin
               line_v      = l2_rdata;
               rsp_rdata_d = l2_rdata[{req_off, 3'b000} +: 8];
               if (req_we_q) begin
                  line_v[{req_off, 3'b000} +: 8] = req_wdata_q;
               end
               data_d[victim_q][req_idx]  = line_v;
               tag_d[victim_q][req_idx]   = req_tag;
               valid_d[victim_q][req_idx] = 1'b1;
               dirty_d[victim_q][req_idx] = req_we_q;
               touch_en    = 1'b1;
               touch_way   = victim_q;
               fill_wait_d = 1'b0;
               state_d     = ST_RESP;
            end
         end

         ST_RESP: begin
            cpu_rsp_valid = 1'b1;
            cpu_rdata     = rsp_rdata_q;
            state_d       = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         req_addr_q  <= '0;
         req_we_q    <= 1'b0;
         req_wdata_q <= '0;
         victim_q    <= '0;
         fill_wait_q <= 1'b0;
         rsp_rdata_q <= '0;
         for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               valid_q[w][s] <= 1'b0;
               dirty_q[w][s] <= 1'b0;
            end
         end
      end else begin
         state_q     <= state_d;
         req_addr_q  <= req_addr_d;
         req_we_q    <= req_we_d;
         req_wdata_q <= req_wdata_d;
         victim_q    <= victim_d;
         fill_wait_q <= fill_wait_d;
         rsp_rdata_q <= rsp_rdata_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
      end
   end

   // Tag and data contents are qualified by valid, so they carry no reset.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Directed bench for l1_cache_ctrl: default 2-way/16-set instance plus a 4-way/8-set instance for LRU order.
module tb_l1_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req_valid [2];
   logic        cpu_req_ready [2];
   logic        cpu_we        [2];
   logic [31:0] cpu_addr      [2];
   logic [7:0]  cpu_wdata     [2];
   logic        cpu_rsp_valid [2];
   logic [7:0]  cpu_rdata     [2];
   logic        cpu_rsp_hit   [2];
   logic        l2_req_valid  [2];
   logic        l2_req_ready  [2];
   logic        l2_req_we     [2];
   logic [31:0] l2_req_addr   [2];
   logic [31:0] l2_wdata      [2];
   logic        l2_rsp_valid  [2];
   logic [31:0] l2_rdata      [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   l1_cache_ctrl u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cpu_req_valid (cpu_req_valid[0]),
      .cpu_req_ready (cpu_req_ready[0]),
      .cpu_we        (cpu_we[0]),
      .cpu_addr      (cpu_addr[0]),
      .cpu_wdata     (cpu_wdata[0]),
      .cpu_rsp_valid (cpu_rsp_valid[0]),
      .cpu_rdata     (cpu_rdata[0]),
      .cpu_rsp_hit   (cpu_rsp_hit[0]),
      .l2_req_valid  (l2_req_valid[0]),
      .l2_req_ready  (l2_req_ready[0]),
      .l2_req_we     (l2_req_we[0]),
      .l2_req_addr   (l2_req_addr[0]),
      .l2_wdata      (l2_wdata[0]),
      .l2_rsp_valid  (l2_rsp_valid[0]),
      .l2_rdata      (l2_rdata[0])
   );

   l1_cache_ctrl #(.WAYS(4), .SETS(8)) u_dut4 (
      .clk           (clk),
      .rst_n         (rst_n),
      .cpu_req_valid (cpu_req_valid[1]),
      .cpu_req_ready (cpu_req_ready[1]),
      .cpu_we        (cpu_we[1]),
      .cpu_addr      (cpu_addr[1]),
      .cpu_wdata     (cpu_wdata[1]),
      .cpu_rsp_valid (cpu_rsp_valid[1]),
      .cpu_rdata     (cpu_rdata[1]),
      .cpu_rsp_hit   (cpu_rsp_hit[1]),
      .l2_req_valid  (l2_req_valid[1]),
      .l2_req_ready  (l2_req_ready[1]),
      .l2_req_we     (l2_req_we[1]),
      .l2_req_addr   (l2_req_addr[1]),
      .l2_wdata      (l2_wdata[1]),
      .l2_rsp_valid  (l2_rsp_valid[1]),
      .l2_rdata      (l2_rdata[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // One CPU transaction on instance d; plays L2, optionally stalling each L2 request for 'stall' cycles.
   task automatic access(input int d, input logic we, input logic [31:0] addr, input logic [7:0] wd,
                         input logic [31:0] fill_line, input int stall,
                         output logic hit, output logic [7:0] rd, output int lat,
                         output logic wb_seen, output logic [31:0] wb_addr, output logic [31:0] wb_data,
                         output logic [31:0] fetch_addr);
      logic        done;
      logic        rsp_pending;
      int          held;
      logic [31:0] held_addr;
      hit = 0; rd = 0; lat = 0; wb_seen = 0; wb_addr = 0; wb_data = 0; fetch_addr = 0;
      done = 0; rsp_pending = 0; held = 0; held_addr = 0;
      @(negedge clk);
      cpu_req_valid[d] = 1; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wd;
      @(negedge clk);
      cpu_req_valid[d] = 0;
      lat = 1;
      for (int c = 0; c < 60 && !done; c++) begin
         l2_req_ready[d] = 0;
         l2_rsp_valid[d] = 0;
         if (cpu_rsp_valid[d]) begin
            hit  = cpu_rsp_hit[d];
            rd   = cpu_rdata[d];
            done = 1;
         end else begin
            if (rsp_pending) begin
               l2_rsp_valid[d] = 1;
               l2_rdata[d]     = fill_line;
               rsp_pending     = 0;
            end else if (held > 0 && held < stall) begin
               chk("stall_l2_valid", l2_req_valid[d], 1);
               chk("stall_l2_addr", l2_req_addr[d], held_addr);
               chk("stall_cpu_ready", cpu_req_ready[d], 0);
               held++;
            end else if (l2_req_valid[d]) begin
               if (held == 0 && stall > 0) begin
                  held_addr = l2_req_addr[d];
                  held      = 1;
               end else begin
                  l2_req_ready[d] = 1;
                  held            = 0;
                  if (l2_req_we[d]) begin
                     wb_seen = 1; wb_addr = l2_req_addr[d]; wb_data = l2_wdata[d];
                  end else begin
                     fetch_addr  = l2_req_addr[d];
                     rsp_pending = 1;
                  end
               end
            end
            @(negedge clk);
            lat++;
         end
      end
      l2_req_ready[d] = 0;
      l2_rsp_valid[d] = 0;
      if (!done) chk("rsp_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        hit;
      logic [7:0]  rd;
      int          lat;
      logic        wbs;
      logic [31:0] wba, wbd, fa;

      rst_n = 0;
      for (int d = 0; d < 2; d++) begin
         cpu_req_valid[d] = 0; cpu_we[d] = 0; cpu_addr[d] = 0; cpu_wdata[d] = 0;
         l2_req_ready[d] = 0; l2_rsp_valid[d] = 0; l2_rdata[d] = 0;
      end
      #1;
      chk("rst_cpu_ready", cpu_req_ready[0], 1);
      chk("rst_rsp_valid", cpu_rsp_valid[0], 0);
      chk("rst_l2_valid", l2_req_valid[0], 0);
      repeat (3) @(negedge clk);
      rst_n = 1;

      // 1: cold read miss, then hit on same line
      access(0, 0, 32'h10, 8'h00, 32'h44332211, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t1_hit", hit, 0); chk("t1_rdata", rd, 8'h11); chk("t1_fetch", fa, 32'h10); chk("t1_wb", wbs, 0);
      access(0, 0, 32'h12, 8'h00, 32'h0, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t1b_hit", hit, 1); chk("t1b_rdata", rd, 8'h33); chk("t1b_lat", lat, 1);

      // 2: write hit returns old byte, then read back
      access(0, 1, 32'h11, 8'hAB, 32'h0, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t2_hit", hit, 1); chk("t2_old", rd, 8'h22); chk("t2_lat", lat, 1);
      access(0, 0, 32'h11, 8'h00, 32'h0, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t2b_hit", hit, 1); chk("t2b_rdata", rd, 8'hAB);

      // 3/4: B fills way1, B dirtied, A touched, C evicts B with 5-cycle L2 stalls
      access(0, 0, 32'h50, 8'h00, 32'h88776655, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t3_b_hit", hit, 0); chk("t3_b_rdata", rd, 8'h55); chk("t3_b_fetch", fa, 32'h50); chk("t3_b_wb", wbs, 0);
      access(0, 1, 32'h53, 8'hCD, 32'h0, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t3_bw_hit", hit, 1); chk("t3_bw_old", rd, 8'h88);
      access(0, 0, 32'h10, 8'h00, 32'h0, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t3_a_hit", hit, 1); chk("t3_a_rdata", rd, 8'h11);
      access(0, 0, 32'h90, 8'h00, 32'hDDCCBBAA, 5, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t3_c_hit", hit, 0); chk("t3_c_wb", wbs, 1); chk("t3_c_wb_addr", wba, 32'h50);
      chk("t3_c_wb_data", wbd, 32'hCD776655); chk("t3_c_fetch", fa, 32'h90); chk("t3_c_rdata", rd, 8'hAA);
      access(0, 0, 32'h10, 8'h00, 32'h0, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t3_a_kept", hit, 1); chk("t3_a_kept_rd", rd, 8'h11);
      access(0, 0, 32'h50, 8'h00, 32'hCD776655, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t3_b_gone", hit, 0); chk("t3_b_clean_victim", wbs, 0); chk("t3_b_refetch", fa, 32'h50);

      // 5a: spurious L2 response while idle
      @(negedge clk);
      l2_rsp_valid[0] = 1; l2_rdata[0] = 32'hFFFFFFFF;
      repeat (2) @(negedge clk);
      l2_rsp_valid[0] = 0;
      access(0, 0, 32'h10, 8'h00, 32'h0, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t5_spur_a_hit", hit, 1); chk("t5_spur_a_rd", rd, 8'h11);
      access(0, 0, 32'h51, 8'h00, 32'h0, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t5_spur_b_hit", hit, 1); chk("t5_spur_b_rd", rd, 8'h66);

      // 5b: reset while in FILL
      @(negedge clk);
      cpu_req_valid[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 32'h200;
      @(negedge clk);
      cpu_req_valid[0] = 0;
      @(negedge clk);
      chk("t5_fill_valid", l2_req_valid[0], 1);
      chk("t5_fill_addr", l2_req_addr[0], 32'h200);
      rst_n = 0;
      #1;
      chk("t5_rst_l2_valid", l2_req_valid[0], 0);
      chk("t5_rst_ready", cpu_req_ready[0], 1);
      chk("t5_rst_rsp", cpu_rsp_valid[0], 0);
      @(negedge clk);
      rst_n = 1;
      access(0, 0, 32'h200, 8'h00, 32'h12345678, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t5_post_hit", hit, 0); chk("t5_post_fetch", fa, 32'h200); chk("t5_post_rd", rd, 8'h78);
      access(0, 0, 32'h10, 8'h00, 32'h44332211, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t5_inval_hit", hit, 0); chk("t5_inval_wb", wbs, 0); chk("t5_inval_fetch", fa, 32'h10);

      // 6: 4-way, set 1; order 0,1(write),2,3,0 -> way1 is the next victim
      access(1, 0, 32'h04, 8'h00, 32'h0F0E0D0C, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t6_w0_hit", hit, 0); chk("t6_w0_rd", rd, 8'h0C); chk("t6_w0_wb", wbs, 0);
      access(1, 1, 32'h25, 8'h5A, 32'h03020100, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t6_w1_hit", hit, 0); chk("t6_w1_old", rd, 8'h01); chk("t6_w1_fetch", fa, 32'h24);
      access(1, 0, 32'h44, 8'h00, 32'h23222120, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t6_w2_hit", hit, 0); chk("t6_w2_rd", rd, 8'h20); chk("t6_w2_wb", wbs, 0);
      access(1, 0, 32'h64, 8'h00, 32'h33323130, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t6_w3_hit", hit, 0); chk("t6_w3_wb", wbs, 0);
      access(1, 0, 32'h04, 8'h00, 32'h0, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t6_w0_rehit", hit, 1); chk("t6_w0_rehit_rd", rd, 8'h0C);
      access(1, 0, 32'h84, 8'h00, 32'h43424140, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t6_evict_hit", hit, 0); chk("t6_evict_wb", wbs, 1); chk("t6_evict_wb_addr", wba, 32'h24);
      chk("t6_evict_wb_data", wbd, 32'h03025A00); chk("t6_evict_fetch", fa, 32'h84); chk("t6_evict_rd", rd, 8'h40);
      access(1, 0, 32'h44, 8'h00, 32'h0, 0, hit, rd, lat, wbs, wba, wbd, fa);
      chk("t6_w2_kept", hit, 1); chk("t6_w2_kept_rd", rd, 8'h20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
